// File: rtl/axi_beat_mem_pkg.sv
// Shared types for axi_beat_mem: response/burst encodings, FSM state enums and the
// default AXI4 request/response structs (64-bit address/data, 3-bit ID, 1-bit user).
package axi_beat_mem_pkg;

  localparam int unsigned PkgAddrWidth = 64;
  localparam int unsigned PkgDataWidth = 64;
  localparam int unsigned PkgIdWidth   = 3;
  localparam int unsigned PkgUserWidth = 1;
  localparam int unsigned PkgStrbWidth = PkgDataWidth / 8;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef struct packed {
    logic [PkgIdWidth-1:0]   id;
    logic [PkgAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [PkgUserWidth-1:0] user;
  } ax_chan_t;

  typedef struct packed {
    logic [PkgDataWidth-1:0] data;
    logic [PkgStrbWidth-1:0] strb;
    logic                    last;
    logic [PkgUserWidth-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [PkgIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [PkgUserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [PkgIdWidth-1:0]   id;
    logic [PkgDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [PkgUserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

endpackage

// File: rtl/axi_beat_mem_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts
// (reserved burst type behaves as INCR).
module axi_beat_mem_addr_gen
  import axi_beat_mem_pkg::*;
#(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [7:0]           len_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
  output logic [AddrWidth-1:0] next_addr_o
);

  logic [AddrWidth-1:0] incr;
  logic [AddrWidth-1:0] aligned;
  logic [AddrWidth-1:0] wrap_bytes;
  logic [AddrWidth-1:0] wrap_mask;

  always_comb begin
    incr       = AddrWidth'(1) << size_i;
    aligned    = addr_i & ~(incr - AddrWidth'(1));
    wrap_bytes = (AddrWidth'(len_i) + AddrWidth'(1)) << size_i;
    wrap_mask  = wrap_bytes - AddrWidth'(1);
    case (burst_i)
      BurstFixed: next_addr_o = addr_i;
      // Upper bits pinned to the wrap boundary, lower bits roll over inside it.
      BurstWrap:  next_addr_o = (addr_i & ~wrap_mask) | ((aligned + incr) & wrap_mask);
      default:    next_addr_o = aligned + incr;
    endcase
  end

endmodule

// File: rtl/axi_beat_mem.sv
// AXI4 slave memory with independent single-outstanding read/write FSMs and
// per-beat monitor outputs; monitor registers exist only with AXI_BEAT_MEM_MON_EN.
module axi_beat_mem
  import axi_beat_mem_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned MemBytes  = 4096,
  parameter type axi_req_t = axi_beat_mem_pkg::axi_req_t,
  parameter type axi_rsp_t = axi_beat_mem_pkg::axi_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  axi_req_t             axi_req_i,
  output axi_rsp_t             axi_rsp_o,
  output logic                 mon_w_valid_o,
  output logic [AddrWidth-1:0] mon_w_addr_o,
  output logic [DataWidth-1:0] mon_w_data_o,
  output logic                 mon_r_valid_o,
  output logic [AddrWidth-1:0] mon_r_addr_o,
  output logic [DataWidth-1:0] mon_r_data_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned Words     = MemBytes / StrbWidth;
  localparam int unsigned MemAw     = $clog2(MemBytes);
  localparam logic [UserWidth-1:0] UserZero = '0;
  localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(StrbWidth - 1);

  logic [DataWidth-1:0] mem_q [Words];

  // ---------------- write path ----------------
  w_state_e             w_state_q, w_state_d;
  logic [IdWidth-1:0]   w_id_q, w_id_d;
  logic [AddrWidth-1:0] w_addr_q, w_addr_d, w_next;
  logic [7:0]           w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]           w_size_q, w_size_d;
  logic [1:0]           w_burst_q, w_burst_d;
  logic                 w_err_q, w_err_d;
  logic                 aw_ready, w_ready, b_valid, w_fire, w_oob;
  logic [DataWidth-1:0] w_old, w_merged;

  axi_beat_mem_addr_gen #(.AddrWidth(AddrWidth)) u_w_addr_gen (
    .addr_i      (w_addr_q),
    .len_i       (w_len_q),
    .size_i      (w_size_q),
    .burst_i     (w_burst_q),
    .next_addr_o (w_next)
  );

  assign w_oob = (w_addr_q >= AddrWidth'(MemBytes));
  assign w_old = w_oob ? '0 : mem_q[w_addr_q[MemAw-1:OffW]];

  always_comb begin
    w_merged = w_old;
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      if (axi_req_i.w.strb[b]) w_merged[b*8 +: 8] = axi_req_i.w.data[b*8 +: 8];
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    w_fire    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = ~rst;
        if (axi_req_i.aw_valid && !rst) begin
          w_id_d    = axi_req_i.aw.id;
          w_addr_d  = axi_req_i.aw.addr;
          w_len_d   = axi_req_i.aw.len;
          w_size_d  = axi_req_i.aw.size;
          w_burst_d = axi_req_i.aw.burst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        // Beat count alone ends the burst; wlast is not trusted.
        if (axi_req_i.w_valid) begin
          w_fire   = 1'b1;
          w_addr_d = w_next;
          w_cnt_d  = w_cnt_q + 8'd1;
          if (w_oob) w_err_d = 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Words; i++) mem_q[i] <= '0;
    end else if (w_fire && !w_oob) begin
      mem_q[w_addr_q[MemAw-1:OffW]] <= w_merged;
    end
  end

  // ---------------- read path ----------------
  r_state_e             r_state_q, r_state_d;
  logic [IdWidth-1:0]   r_id_q, r_id_d;
  logic [AddrWidth-1:0] r_addr_q, r_addr_d, r_next;
  logic [7:0]           r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]           r_size_q, r_size_d;
  logic [1:0]           r_burst_q, r_burst_d;
  logic                 ar_ready, r_valid, r_fire, r_oob, r_last;
  logic [DataWidth-1:0] r_word;

  axi_beat_mem_addr_gen #(.AddrWidth(AddrWidth)) u_r_addr_gen (
    .addr_i      (r_addr_q),
    .len_i       (r_len_q),
    .size_i      (r_size_q),
    .burst_i     (r_burst_q),
    .next_addr_o (r_next)
  );

  // Read from the registered array so a same-cycle write is seen only afterwards.
  assign r_oob  = (r_addr_q >= AddrWidth'(MemBytes));
  assign r_word = r_oob ? '0 : mem_q[r_addr_q[MemAw-1:OffW]];
  assign r_last = (r_cnt_q == r_len_q);

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_fire    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = ~rst;
        if (axi_req_i.ar_valid && !rst) begin
          r_id_d    = axi_req_i.ar.id;
          r_addr_d  = axi_req_i.ar.addr;
          r_len_d   = axi_req_i.ar.len;
          r_size_d  = axi_req_i.ar.size;
          r_burst_d = axi_req_i.ar.burst;
          r_cnt_d   = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (axi_req_i.r_ready) begin
          r_fire = 1'b1;
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next;
            r_cnt_d  = r_cnt_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_ready;
    axi_rsp_o.w_ready  = w_ready;
    axi_rsp_o.b_valid  = b_valid;
    axi_rsp_o.b.id     = w_id_q;
    axi_rsp_o.b.resp   = w_err_q ? RespSlvErr : RespOkay;
    axi_rsp_o.b.user   = UserZero;
    axi_rsp_o.ar_ready = ar_ready;
    axi_rsp_o.r_valid  = r_valid;
    axi_rsp_o.r.id     = r_id_q;
    axi_rsp_o.r.data   = r_word;
    axi_rsp_o.r.resp   = r_oob ? RespSlvErr : RespOkay;
    axi_rsp_o.r.last   = r_last;
    axi_rsp_o.r.user   = UserZero;
  end

  logic unused_inputs;
  assign unused_inputs = ^{axi_req_i.w.last, axi_req_i.w.user,
                           axi_req_i.aw.user, axi_req_i.ar.user};

  // ---------------- monitor ----------------
`ifdef AXI_BEAT_MEM_MON_EN
  logic                 mon_w_valid_q, mon_r_valid_q;
  logic [AddrWidth-1:0] mon_w_addr_q, mon_r_addr_q;
  logic [DataWidth-1:0] mon_w_data_q, mon_r_data_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      mon_w_valid_q <= 1'b0;
      mon_w_addr_q  <= '0;
      mon_w_data_q  <= '0;
      mon_r_valid_q <= 1'b0;
      mon_r_addr_q  <= '0;
      mon_r_data_q  <= '0;
    end else begin
      mon_w_valid_q <= w_fire;
      mon_r_valid_q <= r_fire;
      if (w_fire) begin
        mon_w_addr_q <= w_addr_q & WordMask;
        mon_w_data_q <= w_merged;
      end
      if (r_fire) begin
        mon_r_addr_q <= r_addr_q & WordMask;
        mon_r_data_q <= r_word;
      end
    end
  end

  assign mon_w_valid_o = mon_w_valid_q;
  assign mon_w_addr_o  = mon_w_addr_q;
  assign mon_w_data_o  = mon_w_data_q;
  assign mon_r_valid_o = mon_r_valid_q;
  assign mon_r_addr_o  = mon_r_addr_q;
  assign mon_r_data_o  = mon_r_data_q;
`else
  logic unused_mask;
  assign unused_mask   = ^WordMask;
  assign mon_w_valid_o = 1'b0;
  assign mon_w_addr_o  = '0;
  assign mon_w_data_o  = '0;
  assign mon_r_valid_o = 1'b0;
  assign mon_r_addr_o  = '0;
  assign mon_r_data_o  = '0;
`endif

endmodule

// File: tb/tb_axi_beat_mem.sv
// Directed bench for axi_beat_mem: reset, INCR/FIXED/WRAP bursts, strobes, out-of-range
// accesses, R backpressure and reset mid-burst; monitor checks follow AXI_BEAT_MEM_MON_EN.
module tb_axi_beat_mem;
  import axi_beat_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  axi_req_t    req;
  axi_rsp_t    rsp;
  logic        mw_valid, mr_valid;
  logic [63:0] mw_addr, mw_data, mr_addr, mr_data;
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  axi_beat_mem #(
    .AddrWidth (64),
    .DataWidth (64),
    .IdWidth   (3),
    .UserWidth (1),
    .MemBytes  (4096)
  ) dut (
    .clk_i         (clk),
    .rst           (rst),
    .axi_req_i     (req),
    .axi_rsp_o     (rsp),
    .mon_w_valid_o (mw_valid),
    .mon_w_addr_o  (mw_addr),
    .mon_w_data_o  (mw_data),
    .mon_r_valid_o (mr_valid),
    .mon_r_addr_o  (mr_addr),
    .mon_r_data_o  (mr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mw(input logic [63:0] addr, input logic [63:0] data);
`ifdef AXI_BEAT_MEM_MON_EN
    chk("mon_w_valid", mw_valid, 1);
    chk("mon_w_addr", mw_addr, addr);
    chk("mon_w_data", mw_data, data);
`else
    chk("mon_w_valid_tied", mw_valid, 0);
    chk("mon_w_data_tied", mw_data | mw_addr, 0);
`endif
  endtask

  task automatic chk_mr(input logic [63:0] addr, input logic [63:0] data);
`ifdef AXI_BEAT_MEM_MON_EN
    chk("mon_r_valid", mr_valid, 1);
    chk("mon_r_addr", mr_addr, addr);
    chk("mon_r_data", mr_data, data);
`else
    chk("mon_r_valid_tied", mr_valid, 0);
    chk("mon_r_data_tied", mr_data | mr_addr, 0);
`endif
  endtask

  task automatic send_aw(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] id);
    int n = 0;
    req.aw.addr = addr; req.aw.len = len; req.aw.size = 3'd3;
    req.aw.burst = burst; req.aw.id = id; req.aw_valid = 1'b1;
    while (rsp.aw_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("aw_ready_wait", n < 20, 1);
    tick();
    req.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    req.w.data = data; req.w.strb = strb; req.w.last = last; req.w_valid = 1'b1;
    while (rsp.w_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("w_ready_wait", n < 20, 1);
    tick();
    req.w_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] id);
    int n = 0;
    req.ar.addr = addr; req.ar.len = len; req.ar.size = 3'd3;
    req.ar.burst = burst; req.ar.id = id; req.ar_valid = 1'b1;
    while (rsp.ar_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("ar_ready_wait", n < 20, 1);
    tick();
    req.ar_valid = 1'b0;
  endtask

  initial begin
    req = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;

    // Reset behaviour
    #1;
    chk("rst_aw_ready", rsp.aw_ready, 0);
    chk("rst_ar_ready", rsp.ar_ready, 0);
    chk("rst_b_valid", rsp.b_valid, 0);
    chk("rst_r_valid", rsp.r_valid, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_aw_ready", rsp.aw_ready, 1);
    chk("post_rst_ar_ready", rsp.ar_ready, 1);
    chk("post_rst_w_ready", rsp.w_ready, 0);

    // Single read of never-written word
    send_ar(64'h0, 8'd0, BurstIncr, 3'd1);
    chk("rd0_valid", rsp.r_valid, 1);
    chk("rd0_data", rsp.r.data, 64'h0);
    chk("rd0_resp", rsp.r.resp, RespOkay);
    chk("rd0_last", rsp.r.last, 1);
    chk("rd0_id", rsp.r.id, 3'd1);
    tick();
    chk("rd0_done", rsp.r_valid, 0);
    chk_mr(64'h0, 64'h0);

    // INCR write of two beats at 0x8, then readback
    send_aw(64'h8, 8'd1, BurstIncr, 3'd2);
    send_w(64'h2, 8'hFF, 1'b0);
    chk_mw(64'h8, 64'h2);
    chk("wr1_b_early", rsp.b_valid, 0);
    send_w(64'h1, 8'hFF, 1'b1);
    chk_mw(64'h10, 64'h1);
    chk("wr1_b_valid", rsp.b_valid, 1);
    chk("wr1_b_resp", rsp.b.resp, RespOkay);
    chk("wr1_b_id", rsp.b.id, 3'd2);
    tick();
    chk("wr1_b_done", rsp.b_valid, 0);
    send_ar(64'h8, 8'd1, BurstIncr, 3'd3);
    chk("rd1_b0_data", rsp.r.data, 64'h2);
    chk("rd1_b0_last", rsp.r.last, 0);
    tick();
    chk("rd1_b1_data", rsp.r.data, 64'h1);
    chk("rd1_b1_last", rsp.r.last, 1);
    chk_mr(64'h8, 64'h2);
    tick();
    chk("rd1_done", rsp.r_valid, 0);
    chk_mr(64'h10, 64'h1);

    // Partial strobe
    send_aw(64'h0, 8'd0, BurstIncr, 3'd0);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
    chk_mw(64'h0, 64'h0000_0000_FFFF_FFFF);
    chk("strb_b_resp", rsp.b.resp, RespOkay);
    tick();
    send_ar(64'h0, 8'd0, BurstIncr, 3'd0);
    chk("strb_rd_data", rsp.r.data, 64'h0000_0000_FFFF_FFFF);
    tick();

    // Fill 0x20..0x38, then WRAP read from 0x30 with a 3-cycle rready stall
    send_aw(64'h20, 8'd3, BurstIncr, 3'd4);
    send_w(64'hA0, 8'hFF, 1'b0);
    send_w(64'hA8, 8'hFF, 1'b0);
    send_w(64'hB0, 8'hFF, 1'b0);
    send_w(64'hB8, 8'hFF, 1'b1);
    chk("fill_b_valid", rsp.b_valid, 1);
    tick();
    send_ar(64'h30, 8'd3, BurstWrap, 3'd5);
    chk("wrap_b0_data", rsp.r.data, 64'hB0);
    chk("wrap_b0_last", rsp.r.last, 0);
    tick();
    chk("wrap_b1_data", rsp.r.data, 64'hB8);
    chk_mr(64'h30, 64'hB0);
    req.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", rsp.r_valid, 1);
      chk("stall_data", rsp.r.data, 64'hB8);
      chk("stall_last", rsp.r.last, 0);
      chk("stall_mon_r", mr_valid, 0);
    end
    req.r_ready = 1'b1;
    tick();
    chk("wrap_b2_data", rsp.r.data, 64'hA0);
    chk("wrap_b2_last", rsp.r.last, 0);
    chk_mr(64'h38, 64'hB8);
    tick();
    chk("wrap_b3_data", rsp.r.data, 64'hA8);
    chk("wrap_b3_last", rsp.r.last, 1);
    chk_mr(64'h20, 64'hA0);
    tick();
    chk("wrap_done", rsp.r_valid, 0);
    chk_mr(64'h28, 64'hA8);

    // FIXED burst with early wlast: beat counter still expects two beats
    send_aw(64'h40, 8'd1, BurstFixed, 3'd5);
    send_w(64'h11, 8'hFF, 1'b1);
    chk_mw(64'h40, 64'h11);
    chk("early_last_no_b", rsp.b_valid, 0);
    send_w(64'h22, 8'hFF, 1'b0);
    chk_mw(64'h40, 64'h22);
    chk("fixed_b_valid", rsp.b_valid, 1);
    tick();
    send_ar(64'h40, 8'd1, BurstIncr, 3'd0);
    chk("fixed_rd0", rsp.r.data, 64'h22);
    tick();
    chk("fixed_rd1", rsp.r.data, 64'h0);
    tick();

    // Out-of-range accesses
    send_aw(64'h2000, 8'd0, BurstIncr, 3'd6);
    send_w(64'hDEAD_BEEF_0000_1234, 8'hFF, 1'b1);
    chk("oob_b_valid", rsp.b_valid, 1);
    chk("oob_b_resp", rsp.b.resp, RespSlvErr);
    tick();
    send_ar(64'h2000, 8'd0, BurstIncr, 3'd6);
    chk("oob_r_data", rsp.r.data, 64'h0);
    chk("oob_r_resp", rsp.r.resp, RespSlvErr);
    tick();
    send_ar(64'h0, 8'd0, BurstIncr, 3'd0);
    chk("oob_alias_data", rsp.r.data, 64'h0000_0000_FFFF_FFFF);
    chk("oob_alias_resp", rsp.r.resp, RespOkay);
    tick();

    // Reset mid-burst
    send_ar(64'h20, 8'd3, BurstIncr, 3'd7);
    chk("mid_b0", rsp.r.data, 64'hA0);
    tick();
    chk("mid_b1", rsp.r.data, 64'hA8);
    rst = 1'b1;
    #1;
    chk("mid_rst_r_valid", rsp.r_valid, 0);
    chk("mid_rst_ar_ready", rsp.ar_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_r_valid", rsp.r_valid, 0);
    chk("after_rst_ar_ready", rsp.ar_ready, 1);
    chk("after_rst_aw_ready", rsp.aw_ready, 1);
    send_ar(64'h8, 8'd0, BurstIncr, 3'd0);
    chk("after_rst_cleared", rsp.r.data, 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
